// File: rtl/score_frame_tx.sv
// Score frame transmitter: sends HEADER, four payload bytes and an XOR checksum
// into a UART transmit FIFO, stalling while the FIFO reports full.
module score_frame_tx #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         NBYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_req,
  input  logic [31:0] tx_data,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the checksum byte, which is the last byte of the frame.
  localparam logic [2:0] LAST_IDX = 3'(NBYTES + 1);

  state_t      state_r;
  state_t      state_s;
  logic [2:0]  idx_r;
  logic [2:0]  idx_s;
  logic [31:0] shadow_r;
  logic [7:0]  chk_r;
  logic [7:0]  frame_cnt_r;
  logic        wr_s;
  logic [7:0]  data_s;

  function automatic logic [7:0] xor_bytes(input logic [31:0] word);
    return word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0]  index,
                                            input logic [31:0] payload,
                                            input logic [7:0]  chk);
    logic [7:0] byte_v;
    case (index)
      3'd0:    byte_v = HEADER;
      3'd1:    byte_v = payload[31:24];
      3'd2:    byte_v = payload[23:16];
      3'd3:    byte_v = payload[15:8];
      3'd4:    byte_v = payload[7:0];
      3'd5:    byte_v = chk;
      default: byte_v = 8'h00;
    endcase
    return byte_v;
  endfunction

  // State and byte index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Payload shadow and checksum, captured only when a request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r <= 32'h0000_0000;
      chk_r    <= 8'h00;
    end else if ((state_r == IDLE) && send_req) begin
      shadow_r <= tx_data;
      chk_r    <= xor_bytes(tx_data);
    end else begin
      shadow_r <= shadow_r;
      chk_r    <= chk_r;
    end
  end

  // Completed frame counter, bumped as DONE is left; wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_r <= 8'h00;
    end else if (state_r == DONE) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Next-state, index advance and FIFO write strobe.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    wr_s    = 1'b0;
    data_s  = 8'h00;
    case (state_r)
      IDLE: begin
        if (send_req) begin
          state_s = SEND;
          idx_s   = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        data_s = frame_byte(idx_r, shadow_r, chk_r);
        if (!tx_full) begin
          wr_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            state_s = DONE;
            idx_s   = 3'd0;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          wr_s = 1'b0;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        idx_s   = 3'd0;
      end
    endcase
  end

  // The FIFO write path must react to tx_full in the same cycle, so it stays combinational.
  assign wr_uart    = wr_s;
  assign data_out   = data_s;
  assign busy       = (state_r == SEND) || (state_r == DONE);
  assign frame_done = (state_r == DONE);
  assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_score_frame_tx.sv
// Directed self-checking bench for score_frame_tx.
module tb_score_frame_tx;

  logic        clk;
  logic        rst;
  logic        send_req;
  logic [31:0] tx_data;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  data_out;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  int checks;
  int errors;

  logic [31:0] d1;
  logic [7:0]  exp_b [0:5];

  score_frame_tx #(.HEADER(8'hA5), .NBYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .send_req   (send_req),
    .tx_data    (tx_data),
    .tx_full    (tx_full),
    .wr_uart    (wr_uart),
    .data_out   (data_out),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive inputs after the falling edge, then settle before sampling.
  task automatic step(input logic sr, input logic full, input logic [31:0] d);
    @(negedge clk);
    send_req = sr;
    tx_full  = full;
    tx_data  = d;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (wr_uart !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
        data_out !== 8'h00 || frame_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: wr=%b busy=%b done=%b data=%h cnt=%h, want all zero",
               wr_uart, busy, frame_done, data_out, frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    step(1'b1, 1'b0, d1);
    checks++;
    if (busy !== 1'b0 || wr_uart !== 1'b0) begin
      errors++;
      $display("FAIL basic_c0: busy=%b wr=%b, want 0 0", busy, wr_uart);
    end
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, d1);
      checks++;
      if (wr_uart !== 1'b1 || data_out !== exp_b[i-1] || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_byte%0d: wr=%b data=%h busy=%b, want 1 %h 1",
                 i, wr_uart, data_out, busy, exp_b[i-1]);
      end
    end
    step(1'b0, 1'b0, d1);
    checks++;
    if (frame_done !== 1'b1 || wr_uart !== 1'b0 || data_out !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: done=%b wr=%b data=%h busy=%b, want 1 0 00 1",
               frame_done, wr_uart, data_out, busy);
    end
    step(1'b0, 1'b0, d1);
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL basic_idle: done=%b busy=%b cnt=%0d, want 0 0 1",
               frame_done, busy, frame_cnt);
    end
  endtask

  task automatic test_stall();
    int k;
    logic full;
    k = 0;
    step(1'b1, 1'b0, d1);
    for (int c = 1; c <= 9; c++) begin
      full = (c >= 2 && c <= 4);
      step(1'b0, full, d1);
      checks++;
      if (wr_uart !== !full || data_out !== exp_b[k] || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL stall_c%0d: wr=%b data=%h done=%b, want %b %h 0",
                 c, wr_uart, data_out, frame_done, !full, exp_b[k]);
      end
      if (wr_uart === 1'b1 && k < 5) k++;
    end
    step(1'b0, 1'b0, d1);
    checks++;
    if (frame_done !== 1'b1 || wr_uart !== 1'b0 || k !== 5) begin
      errors++;
      $display("FAIL stall_done: done=%b wr=%b last_idx=%0d, want 1 0 5", frame_done, wr_uart, k);
    end
    step(1'b0, 1'b0, d1);
    checks++;
    if (frame_cnt !== 8'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_cnt: cnt=%0d busy=%b, want 2 0", frame_cnt, busy);
    end
  endtask

  task automatic test_ignore_req();
    logic [31:0] d;
    logic        sr;
    step(1'b1, 1'b0, d1);
    for (int c = 1; c <= 7; c++) begin
      d  = (c >= 2) ? 32'hDEAD_BEEF : d1;
      sr = (c == 3 || c == 7);
      step(sr, 1'b0, d);
      if (c <= 6) begin
        checks++;
        if (wr_uart !== 1'b1 || data_out !== exp_b[c-1]) begin
          errors++;
          $display("FAIL ignore_byte%0d: wr=%b data=%h, want 1 %h", c, wr_uart, data_out, exp_b[c-1]);
        end
      end else begin
        checks++;
        if (frame_done !== 1'b1) begin
          errors++;
          $display("FAIL ignore_done: done=%b, want 1", frame_done);
        end
      end
    end
    for (int c = 8; c <= 10; c++) begin
      step(1'b0, 1'b0, 32'hDEAD_BEEF);
      checks++;
      if (busy !== 1'b0 || wr_uart !== 1'b0 || frame_cnt !== 8'd3) begin
        errors++;
        $display("FAIL ignore_idle_c%0d: busy=%b wr=%b cnt=%0d, want 0 0 3",
                 c, busy, wr_uart, frame_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d2;
    logic [7:0]  e2 [0:5];
    d2 = 32'hABCD_EF01;
    e2[0] = 8'hA5; e2[1] = 8'hAB; e2[2] = 8'hCD;
    e2[3] = 8'hEF; e2[4] = 8'h01; e2[5] = 8'h88;
    step(1'b1, 1'b0, d1);
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, 1'b0, d1);
      checks++;
      if (wr_uart !== 1'b1 || data_out !== exp_b[c-1]) begin
        errors++;
        $display("FAIL arst_pre%0d: wr=%b data=%h, want 1 %h", c, wr_uart, data_out, exp_b[c-1]);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (wr_uart !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
        data_out !== 8'h00 || frame_cnt !== 8'h00) begin
      errors++;
      $display("FAIL arst_immediate: wr=%b busy=%b done=%b data=%h cnt=%h, want all zero",
               wr_uart, busy, frame_done, data_out, frame_cnt);
    end
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b0, d1);
      checks++;
      if (wr_uart !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL arst_hold%0d: wr=%b busy=%b, want 0 0", c, wr_uart, busy);
      end
    end
    step(1'b0, 1'b0, d1);
    checks++;
    if (wr_uart !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_release: wr=%b busy=%b, want 0 0", wr_uart, busy);
    end
    @(negedge clk);
    rst      = 1'b0;
    send_req = 1'b1;
    tx_data  = d2;
    #1;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, d2);
      checks++;
      if (wr_uart !== 1'b1 || data_out !== e2[i-1]) begin
        errors++;
        $display("FAIL arst_new%0d: wr=%b data=%h, want 1 %h", i, wr_uart, data_out, e2[i-1]);
      end
    end
    step(1'b0, 1'b0, d2);
    step(1'b0, 1'b0, d2);
    checks++;
    if (frame_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_cnt: cnt=%0d busy=%b, want 1 0", frame_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    int nd;
    int nw;
    nd = 0;
    nw = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 2048; c++) begin
      step(c < 2048, 1'b0, d1);
      if (wr_uart === 1'b1) nw++;
      if (frame_done === 1'b1) begin
        nd++;
        checks++;
        if (c != 7 + 8 * (nd - 1) || frame_cnt !== 8'((nd - 1) % 256)) begin
          errors++;
          $display("FAIL b2b_done%0d: cycle=%0d cnt=%0d, want cycle %0d cnt %0d",
                   nd, c, frame_cnt, 7 + 8 * (nd - 1), (nd - 1) % 256);
        end
      end
    end
    checks++;
    if (nd != 256 || nw != 1536 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_total: frames=%0d writes=%0d cnt=%0d, want 256 1536 0",
               nd, nw, frame_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    send_req = 1'b0;
    tx_full  = 1'b0;
    tx_data  = 32'h0000_0000;
    d1       = 32'h0100_1234;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h01; exp_b[2] = 8'h00;
    exp_b[3] = 8'h12; exp_b[4] = 8'h34; exp_b[5] = 8'h27;
    test_reset();
    test_basic_frame();
    test_stall();
    test_ignore_req();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_frame_tx.md
SCORE_FRAME_TX -- requirements
Module: score_frame_tx

Interface
REQ-001 Parameter HEADER, default 8'hA5, is the frame start byte.
REQ-002 Parameter NBYTES, default 4, is the payload byte count; only 4 is supported.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 send_req  input  1  request to send one frame; sampled only in IDLE.
REQ-006 tx_data  input  32  payload word {board_ID, BCD points}; latched on an accepted send_req.
REQ-007 tx_full  input  1  UART transmit FIFO full flag.
REQ-008 wr_uart  output  1  one-cycle write strobe to the UART transmit FIFO.
REQ-009 data_out  output  8  byte presented with wr_uart.
REQ-010 busy  output  1  high from the cycle after acceptance until frame_done inclusive.
REQ-011 frame_done  output  1  one-cycle pulse after the last byte is written.
REQ-012 frame_cnt  output  8  number of completed frames, modulo 256.

Function
REQ-013 The FSM SHALL have states IDLE, SEND and DONE, plus a 3-bit byte index idx (0..5).
REQ-014 In IDLE, send_req=1 SHALL latch tx_data into a shadow register, compute chk = XOR of its four bytes, clear idx, and enter SEND on the next edge.
REQ-015 The frame SHALL be, in order: HEADER, tx_data[31:24], [23:16], [15:8], [7:0], chk (6 bytes).
REQ-016 In SEND, wr_uart SHALL be combinational: (state==SEND) && !tx_full; data_out SHALL equal frame byte idx.
REQ-017 Each cycle with wr_uart=1 SHALL increment idx; when tx_full=1, idx and data_out SHALL hold and wr_uart SHALL be 0.
REQ-018 The write with idx=5 SHALL move the FSM to DONE; no byte SHALL ever be written twice or skipped.
REQ-019 DONE SHALL last exactly one cycle with frame_done=1, increment frame_cnt (255 wraps to 0), then return to IDLE.
REQ-020 send_req while in SEND or DONE SHALL be ignored and not queued; tx_data changes after latch SHALL NOT affect the frame in flight.
REQ-021 With tx_full held 0, latency SHALL be: send_req in cycle 0, wr_uart in cycles 1-6, frame_done in cycle 7, IDLE (ready) in cycle 8.
REQ-022 send_req held high continuously SHALL produce back-to-back frames, one every 8 cycles.
REQ-023 busy SHALL be 1 exactly when state is SEND or DONE.
REQ-024 Outside SEND, data_out SHALL be 8'h00 and wr_uart SHALL be 0.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, idx=0, shadow=0, chk=0, frame_cnt=0, wr_uart=0, busy=0, frame_done=0 and data_out=8'h00, without waiting for clk.
REQ-026 rst asserted mid-frame SHALL abandon the frame with no further writes; after release, the block SHALL wait for a new send_req.
REQ-027 The first edge after rst deasserts SHALL be able to accept send_req.

Verification
REQ-028 tx_data=32'h01_00_12_34, tx_full=0, send_req pulse -> wr_uart in cycles 1-6 with bytes A5,01,00,12,34,27; frame_done in cycle 7; frame_cnt=1.
REQ-029 Same frame with tx_full=1 during cycles 2-4 -> bytes A5 then (stall, wr_uart=0) 01,00,12,34,27; no duplicates; frame_done 3 cycles late.
REQ-030 send_req pulses in cycles 3 and 7 of a frame, plus tx_data changed in cycle 2 -> a single frame carrying the original payload; IDLE in cycle 8.
REQ-031 rst asserted asynchronously between byte 3 and byte 4 -> outputs cleared the same cycle, no further writes; a new send_req then yields a full 6-byte frame and frame_cnt=1.
REQ-032 send_req held high for 256 frames -> frame_cnt wraps to 0; frame_done pulses every 8 cycles.
